// File: rtl/bcd_scan_counter.sv
// N-digit BCD up/down counter with tick divider, parallel load and a multiplexed
// active-low 7-segment scan driver. Define LEADING_ZERO_BLANK_EN to blank leading zeros.
module bcd_scan_counter #(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 5000000,
  parameter int SCAN_DIV = 10000
) (
  input  logic                  clk_in1,
  input  logic                  clr,
  input  logic                  enable,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  carry_out,
  output logic [7:0]            an,
  output logic [6:0]            seg
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int SW = $clog2(SCAN_DIV);

  logic [TW-1:0]       tick_cnt;
  logic                tick;
  logic [SW-1:0]       scan_cnt;
  logic                scan_tc;
  logic [2:0]          scan_idx;
  logic [4*DIGITS-1:0] count_step;
  logic [4*DIGITS-1:0] load_clamp;
  logic                wrap;
  logic [3:0]          cur_digit;
  logic                lead_zero;
  logic [7:0]          an_nxt;
  logic [6:0]          seg_nxt;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    case (d)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b1111111;
    endcase
  endfunction

  assign tick    = (tick_cnt == TW'(TICK_DIV - 1));
  assign scan_tc = (scan_cnt == SW'(SCAN_DIV - 1));

  // Load restarts the tick period so the first tick after a load is a full period away.
  always_ff @(posedge clk_in1 or posedge clr) begin
    if (clr)               tick_cnt <= '0;
    else if (load || tick) tick_cnt <= '0;
    else                   tick_cnt <= tick_cnt + 1'b1;
  end

  // Ripple the +/-1 through the digits; wrap stays set only while every digit rolls over.
  always_comb begin
    logic [3:0] d;
    count_step = count;
    load_clamp = '0;
    wrap       = 1'b1;
    d          = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = count[4*i +: 4];
      if (wrap) begin
        if (up_down) begin
          count_step[4*i +: 4] = (d == 4'd9) ? 4'd0 : d + 4'd1;
          wrap = (d == 4'd9);
        end else begin
          count_step[4*i +: 4] = (d == 4'd0) ? 4'd9 : d - 4'd1;
          wrap = (d == 4'd0);
        end
      end
      load_clamp[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  always_ff @(posedge clk_in1 or posedge clr) begin
    if (clr) begin
      count     <= '0;
      carry_out <= 1'b0;
    end else begin
      carry_out <= 1'b0;
      if (load) begin
        count <= load_clamp;
      end else if (tick && enable) begin
        count     <= count_step;
        carry_out <= wrap;
      end
    end
  end

  always_ff @(posedge clk_in1 or posedge clr) begin
    if (clr) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_tc) begin
      scan_cnt <= '0;
      scan_idx <= (scan_idx == 3'(DIGITS - 1)) ? 3'd0 : scan_idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  // lead_zero: selected digit and every digit above it are zero.
  always_comb begin
    cur_digit = '0;
    lead_zero = 1'b1;
    an_nxt    = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (3'(i) == scan_idx) cur_digit = count[4*i +: 4];
      if (3'(i) >= scan_idx && count[4*i +: 4] != 4'd0) lead_zero = 1'b0;
    end
    an_nxt[scan_idx] = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    seg_nxt = (lead_zero && scan_idx != 3'd0) ? 7'b1111111 : seg_decode(cur_digit);
`else
    seg_nxt = seg_decode(cur_digit);
`endif
  end

  always_ff @(posedge clk_in1 or posedge clr) begin
    if (clr) begin
      an  <= 8'hFE;
      seg <= 7'b1000000;
    end else begin
      an  <= an_nxt;
      seg <= seg_nxt;
    end
  end

endmodule
